gs_id_stage: RTL and testbench



---
 rtl/gs_pkg.sv | 58 +++++
 rtl/gs_id_decode.sv | 139 +++++++++++++
 rtl/gs_id_stage.sv | 144 ++++++++++++++
 tb/tb_gs_id_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// GoldenSnitch shared types: opcodes, ALU codes, imm kinds,
// decode control bundle and ID-stage storage state.
package gs_pkg;

  localparam int XLEN_P = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [3:0] PLUS    = 4'b0000;
  localparam logic [3:0] FORWARD = 4'b1011;

  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;

  typedef struct packed {
    logic [2:0]        imm_type;
    logic              pc_to_reg_src;
    logic [3:0]        alu_type;
    logic              b_type;
    logic [1:0]        pc_src;
    logic              mem_write;
    logic              mem_read;
    logic              rd_src;
    logic              alu_src;
    logic              reg_write;
    logic [2:0]        data_size;
    logic [XLEN_P-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              muldiv;
  } gs_ctrl_t;

  typedef struct packed {
    gs_ctrl_t          ctrl;
    logic              illegal;
    logic [XLEN_P-1:0] pc;
  } gs_id_bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } gs_id_state_e;

endpackage

// File: rtl/gs_id_decode.sv
// Combinational RV32I(+M) decoder: instr -> gs_ctrl_t, illegal.
// Ports: instr (in 32), ctrl (out gs_ctrl_t), illegal (out 1).
module gs_id_decode
  import gs_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0] instr,
  output gs_ctrl_t    ctrl,
  output logic        illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25],
                  instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31],
                  instr[19:12], instr[20],
                  instr[30:21], 1'b0};

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    ctrl.rs1 = instr[19:15];
    ctrl.rs2 = instr[24:20];
    ctrl.rd  = instr[11:7];
    unique case (1'b1)
      (opc == OPC_OP): begin
        ctrl.alu_type  = {f7[5], f3};
        ctrl.reg_write = 1'b1;
        if (EN_M && f7 == 7'b0000001)
          ctrl.muldiv = 1'b1;
        else if (f7 != 7'b0000000 &&
                 f7 != 7'b0100000)
          illegal = 1'b1;
      end
      (opc == OPC_OP_IMM): begin
        ctrl.imm_type  = IMM_I;
        ctrl.imm       = imm_i;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_type  = (f3 == 3'b101) ?
                         {f7[5], f3} : {1'b0, f3};
      end
      (opc == OPC_LOAD): begin
        ctrl.imm_type  = IMM_I;
        ctrl.imm       = imm_i;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_type  = PLUS;
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.data_size = f3;
        if (f3 == 3'b011 || f3 == 3'b110 ||
            f3 == 3'b111)
          illegal = 1'b1;
      end
      (opc == OPC_STORE): begin
        ctrl.imm_type  = IMM_S;
        ctrl.imm       = imm_s;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_type  = PLUS;
        ctrl.mem_write = 1'b1;
        ctrl.data_size = f3;
        if (f3 > 3'b010)
          illegal = 1'b1;
      end
      (opc == OPC_BRANCH): begin
        ctrl.imm_type = IMM_B;
        ctrl.imm      = imm_b;
        ctrl.alu_type = {1'b1, f3};
        ctrl.b_type   = 1'b1;
        ctrl.pc_src   = 2'b11;
        if (f3 == 3'b010 || f3 == 3'b011)
          illegal = 1'b1;
      end
      (opc == OPC_JALR): begin
        ctrl.imm_type  = IMM_I;
        ctrl.imm       = imm_i;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_type  = PLUS;
        ctrl.pc_src    = 2'b10;
        ctrl.rd_src    = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      (opc == OPC_JAL): begin
        ctrl.imm_type  = IMM_J;
        ctrl.imm       = imm_j;
        ctrl.alu_type  = PLUS;
        ctrl.pc_src    = 2'b01;
        ctrl.rd_src    = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      (opc == OPC_AUIPC): begin
        ctrl.imm_type      = IMM_U;
        ctrl.imm           = imm_u;
        ctrl.alu_type      = FORWARD;
        ctrl.rd_src        = 1'b1;
        ctrl.pc_to_reg_src = 1'b1;
        ctrl.reg_write     = 1'b1;
      end
      (opc == OPC_LUI): begin
        ctrl.imm_type  = IMM_U;
        ctrl.imm       = imm_u;
        ctrl.alu_type  = FORWARD;
        ctrl.rd_src    = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11)
      illegal = 1'b1;
    // Illegal words still travel so the trap sees
    // their PC, but must have no side effects.
    if (illegal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.mem_read  = 1'b0;
      ctrl.pc_src    = 2'b00;
      ctrl.b_type    = 1'b0;
      ctrl.muldiv    = 1'b0;
    end
  end

endmodule

// File: rtl/gs_id_stage.sv
// Registered ID stage: decode + output reg + 1-entry skid,
// valid/ready in and out, flush, saturating illegal counter.
module gs_id_stage
  import gs_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit EN_M  = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [2:0]       ImmType,
  output logic             PCtoRegSrc,
  output logic [3:0]       ALUType,
  output logic             BType,
  output logic [1:0]       PCSrc,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             RDSrc,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic [2:0]       DataSize,
  output logic [XLEN-1:0]  imm,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic             muldiv_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  gs_id_state_e  state;
  gs_id_state_e  state_n;
  gs_id_bundle_t dec_b;
  gs_id_bundle_t out_q;
  gs_id_bundle_t skid_q;
  gs_ctrl_t      dec_ctrl;
  logic          dec_ill;
  logic          rdy_q;
  logic          push;
  logic          pop;
  logic          load_out;
  logic          from_skid;
  logic          load_skid;
  logic [CNT_W-1:0] cnt_q;

  gs_id_decode #(.EN_M(EN_M)) u_dec (
    .instr   (instr_i),
    .ctrl    (dec_ctrl),
    .illegal (dec_ill)
  );

  assign dec_b.ctrl    = dec_ctrl;
  assign dec_b.illegal = dec_ill;
  assign dec_b.pc      = pc_i;

  assign out_valid_o = (state != EMPTY);
  assign in_ready_o  = rdy_q;
  assign push        = in_valid_i & rdy_q;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    state_n   = state;
    load_out  = 1'b0;
    from_skid = 1'b0;
    load_skid = 1'b0;
    if (flush_i) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (push) begin
          load_out = 1'b1;
          state_n  = FULL;
        end
        FULL: begin
          if (push && pop) begin
            load_out = 1'b1;
          end else if (push) begin
            load_skid = 1'b1;
            state_n   = SKID;
          end else if (pop) begin
            state_n = EMPTY;
          end
        end
        SKID: if (pop) begin
          load_out  = 1'b1;
          from_skid = 1'b1;
          state_n   = FULL;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      rdy_q  <= 1'b1;
      out_q  <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_n;
      rdy_q <= (state_n != SKID);
      if (load_out)
        out_q <= from_skid ? skid_q : dec_b;
      if (load_skid)
        skid_q <= dec_b;
      // A handshake that coincides with flush
      // still completed, so it is counted.
      if (pop && out_q.illegal && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign pc_o          = out_q.pc;
  assign ImmType       = out_q.ctrl.imm_type;
  assign PCtoRegSrc    = out_q.ctrl.pc_to_reg_src;
  assign ALUType       = out_q.ctrl.alu_type;
  assign BType         = out_q.ctrl.b_type;
  assign PCSrc         = out_q.ctrl.pc_src;
  assign MemWrite      = out_q.ctrl.mem_write;
  assign MemRead       = out_q.ctrl.mem_read;
  assign RDSrc         = out_q.ctrl.rd_src;
  assign ALUSrc        = out_q.ctrl.alu_src;
  assign RegWrite      = out_q.ctrl.reg_write;
  assign DataSize      = out_q.ctrl.data_size;
  assign imm           = out_q.ctrl.imm;
  assign rs1_addr      = out_q.ctrl.rs1;
  assign rs2_addr      = out_q.ctrl.rs2;
  assign rd_addr       = out_q.ctrl.rd;
  assign muldiv_o      = out_q.ctrl.muldiv;
  assign illegal_o     = out_q.illegal;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_gs_id_stage.sv
// Directed bench for gs_id_stage (EN_M=0 and EN_M=1
// instances, CNT_W=4), one task per scenario.
module tb_gs_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;

  logic        in_ready_o, out_valid_o;
  logic [31:0] pc_o, imm;
  logic [2:0]  ImmType, DataSize;
  logic [3:0]  ALUType;
  logic [1:0]  PCSrc;
  logic        PCtoRegSrc, BType, MemWrite, MemRead;
  logic        RDSrc, ALUSrc, RegWrite;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        muldiv_o, illegal_o;
  logic [3:0]  illegal_cnt_o;

  logic        m_in_ready, m_out_valid;
  logic [31:0] m_pc, m_imm;
  logic [2:0]  m_ImmType, m_DataSize;
  logic [3:0]  m_ALUType;
  logic [1:0]  m_PCSrc;
  logic        m_PCtoRegSrc, m_BType, m_MemWrite, m_MemRead;
  logic        m_RDSrc, m_ALUSrc, m_RegWrite;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic        m_muldiv, m_illegal;
  logic [3:0]  m_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gs_id_stage #(.XLEN(32), .EN_M(1'b0), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .ImmType(ImmType), .PCtoRegSrc(PCtoRegSrc),
    .ALUType(ALUType), .BType(BType), .PCSrc(PCSrc),
    .MemWrite(MemWrite), .MemRead(MemRead), .RDSrc(RDSrc),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .DataSize(DataSize), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .muldiv_o(muldiv_o),
    .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
  );

  gs_id_stage #(.XLEN(32), .EN_M(1'b1), .CNT_W(4)) dut_m (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(m_in_ready),
    .instr_i(instr_i), .pc_i(pc_i),
    .out_valid_o(m_out_valid), .out_ready_i(out_ready_i),
    .pc_o(m_pc), .ImmType(m_ImmType),
    .PCtoRegSrc(m_PCtoRegSrc), .ALUType(m_ALUType),
    .BType(m_BType), .PCSrc(m_PCSrc),
    .MemWrite(m_MemWrite), .MemRead(m_MemRead),
    .RDSrc(m_RDSrc), .ALUSrc(m_ALUSrc),
    .RegWrite(m_RegWrite), .DataSize(m_DataSize),
    .imm(m_imm), .rs1_addr(m_rs1), .rs2_addr(m_rs2),
    .rd_addr(m_rd), .muldiv_o(m_muldiv),
    .illegal_o(m_illegal), .illegal_cnt_o(m_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i,
                      input logic [31:0] p);
    in_valid_i = 1'b1;
    instr_i    = i;
    pc_i       = p;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid got=%b exp=0", out_valid_o);
    end
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=1", in_ready_o);
    end
    checks++;
    if (illegal_cnt_o !== 4'd0) begin
      failures++;
      $display("FAIL rst_cnt got=%0d exp=0", illegal_cnt_o);
    end
    checks++;
    if ({pc_o, imm, RegWrite, illegal_o, muldiv_o}
        !== 67'd0) begin
      failures++;
      $display("FAIL rst_bundle pc=%h imm=%h rw=%b ill=%b",
               pc_o, imm, RegWrite, illegal_o);
    end
    send(32'hFFB10093, 32'h40);
    in_valid_i = 1'b0;
    rst = 1'b0;
    #2;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL async_rst valid=%b ready=%b exp 0/1",
               out_valid_o, in_ready_o);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_decode();
    do_reset();
    out_ready_i = 1'b1;
    send(32'hFFB10093, 32'h100);
    checks++;
    if (out_valid_o !== 1'b1 || imm !== 32'hFFFFFFFB ||
        ImmType !== 3'd1 || RegWrite !== 1'b1 ||
        ALUSrc !== 1'b1 || illegal_o !== 1'b0) begin
      failures++;
      $display("FAIL addi v=%b imm=%h it=%0d rw=%b ill=%b",
               out_valid_o, imm, ImmType, RegWrite, illegal_o);
    end
    checks++;
    if (rd_addr !== 5'd1 || rs1_addr !== 5'd2 ||
        pc_o !== 32'h100) begin
      failures++;
      $display("FAIL addi_regs rd=%0d rs1=%0d pc=%h",
               rd_addr, rs1_addr, pc_o);
    end
    send(32'h123452B7, 32'h104);
    checks++;
    if (imm !== 32'h12345000 || RDSrc !== 1'b1 ||
        rd_addr !== 5'd5 || ImmType !== 3'd4) begin
      failures++;
      $display("FAIL lui imm=%h rds=%b rd=%0d it=%0d",
               imm, RDSrc, rd_addr, ImmType);
    end
    send(32'h4041D193, 32'h108);
    checks++;
    if (ALUType !== 4'b1101) begin
      failures++;
      $display("FAIL srai alu=%b exp=1101", ALUType);
    end
    send(32'h00512423, 32'h10C);
    checks++;
    if (MemWrite !== 1'b1 || imm !== 32'd8 ||
        DataSize !== 3'd2 || RegWrite !== 1'b0 ||
        rs2_addr !== 5'd5 || ImmType !== 3'd2) begin
      failures++;
      $display("FAIL sw mw=%b imm=%h ds=%0d rw=%b rs2=%0d",
               MemWrite, imm, DataSize, RegWrite, rs2_addr);
    end
    send(32'h00013083, 32'h110);
    checks++;
    if (illegal_o !== 1'b1 || MemRead !== 1'b0 ||
        RegWrite !== 1'b0) begin
      failures++;
      $display("FAIL ld_illegal ill=%b mr=%b rw=%b",
               illegal_o, MemRead, RegWrite);
    end
    send(32'h00002063, 32'h114);
    checks++;
    if (illegal_o !== 1'b1 || BType !== 1'b0 ||
        PCSrc !== 2'b00) begin
      failures++;
      $display("FAIL br_illegal ill=%b bt=%b pcs=%b",
               illegal_o, BType, PCSrc);
    end
    send(32'h000000EF, 32'h118);
    checks++;
    if (PCSrc !== 2'b01 || RegWrite !== 1'b1 ||
        illegal_o !== 1'b0) begin
      failures++;
      $display("FAIL jal pcs=%b rw=%b ill=%b",
               PCSrc, RegWrite, illegal_o);
    end
    in_valid_i = 1'b0;
    step();
    checks++;
    if (out_valid_o !== 1'b0 || illegal_cnt_o !== 4'd2) begin
      failures++;
      $display("FAIL dec_drain v=%b cnt=%0d exp 0/2",
               out_valid_o, illegal_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready_i = 1'b0;
    send(32'hFFB10093, 32'h200);
    checks++;
    if (out_valid_o !== 1'b1 || in_ready_o !== 1'b1 ||
        pc_o !== 32'h200) begin
      failures++;
      $display("FAIL b2b_1 v=%b r=%b pc=%h",
               out_valid_o, in_ready_o, pc_o);
    end
    send(32'h123452B7, 32'h204);
    checks++;
    if (in_ready_o !== 1'b0 || pc_o !== 32'h200 ||
        imm !== 32'hFFFFFFFB) begin
      failures++;
      $display("FAIL b2b_skid r=%b pc=%h imm=%h",
               in_ready_o, pc_o, imm);
    end
    out_ready_i = 1'b1;
    instr_i = 32'h4041D193;
    pc_i = 32'h208;
    step();
    checks++;
    if (pc_o !== 32'h204 || imm !== 32'h12345000 ||
        in_ready_o !== 1'b1 || out_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_2 pc=%h imm=%h r=%b v=%b",
               pc_o, imm, in_ready_o, out_valid_o);
    end
    step();
    checks++;
    if (pc_o !== 32'h208 || ALUType !== 4'b1101 ||
        out_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_3 pc=%h alu=%b v=%b",
               pc_o, ALUType, out_valid_o);
    end
    in_valid_i = 1'b0;
    step();
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end v=%b exp=0", out_valid_o);
    end
  endtask

  task automatic test_muldiv();
    do_reset();
    out_ready_i = 1'b0;
    send(32'h02208033, 32'h300);
    in_valid_i = 1'b0;
    checks++;
    if (illegal_o !== 1'b1 || RegWrite !== 1'b0 ||
        muldiv_o !== 1'b0 || illegal_cnt_o !== 4'd0) begin
      failures++;
      $display("FAIL mul_nom ill=%b rw=%b md=%b cnt=%0d",
               illegal_o, RegWrite, muldiv_o, illegal_cnt_o);
    end
    checks++;
    if (m_muldiv !== 1'b1 || m_illegal !== 1'b0 ||
        m_RegWrite !== 1'b1 || m_ALUType !== 4'b0000) begin
      failures++;
      $display("FAIL mul_m md=%b ill=%b rw=%b alu=%b",
               m_muldiv, m_illegal, m_RegWrite, m_ALUType);
    end
    out_ready_i = 1'b1;
    step();
    checks++;
    if (illegal_cnt_o !== 4'd1 || m_cnt !== 4'd0 ||
        out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL mul_cnt cnt=%0d mcnt=%0d v=%b",
               illegal_cnt_o, m_cnt, out_valid_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready_i = 1'b0;
    send(32'hFFB10093, 32'h400);
    send(32'h123452B7, 32'h404);
    checks++;
    if (in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL fl_skid r=%b exp=0", in_ready_o);
    end
    flush_i = 1'b1;
    instr_i = 32'h4041D193;
    pc_i = 32'h408;
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL fl_state v=%b r=%b exp 0/1",
               out_valid_o, in_ready_o);
    end
    out_ready_i = 1'b1;
    step();
    step();
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL fl_none v=%b exp=0", out_valid_o);
    end
    do_reset();
    out_ready_i = 1'b0;
    send(32'h00000000, 32'h500);
    in_valid_i = 1'b0;
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    checks++;
    if (illegal_cnt_o !== 4'd1 || out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL fl_count cnt=%0d v=%b exp 1/0",
               illegal_cnt_o, out_valid_o);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    out_ready_i = 1'b1;
    in_valid_i = 1'b1;
    instr_i = 32'h0;
    pc_i = 32'h600;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (illegal_cnt_o !== 4'd14) begin
      failures++;
      $display("FAIL sat_14 cnt=%0d exp=14", illegal_cnt_o);
    end
    step();
    checks++;
    if (illegal_cnt_o !== 4'd15) begin
      failures++;
      $display("FAIL sat_15 cnt=%0d exp=15", illegal_cnt_o);
    end
    step();
    in_valid_i = 1'b0;
    step();
    checks++;
    if (illegal_cnt_o !== 4'd15) begin
      failures++;
      $display("FAIL sat_hold cnt=%0d exp=15", illegal_cnt_o);
    end
    step();
    checks++;
    if (out_valid_o !== 1'b0 || illegal_cnt_o !== 4'd15) begin
      failures++;
      $display("FAIL sat_end v=%b cnt=%0d",
               out_valid_o, illegal_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_muldiv();
    test_flush();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
